// File: rtl/rr_arbiter8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter8 : 8-way round-robin arbiter, one-hot registered grant, optional hold limit
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_arbiter8 #(
  parameter int MAX_HOLD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic       grant_valid,
  output logic [2:0] grant_idx,
  output logic       any_req
);

  localparam logic [0:0] c_S_IDLE    = 1'b0;
  localparam logic [0:0] c_S_GRANT   = 1'b1;
  localparam logic [7:0] c_HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);
  localparam logic [7:0] c_HOLD_SAT  = 8'd255;

  logic [0:0] r_state;
  logic [7:0] r_grant;
  logic [2:0] r_idx;
  logic [2:0] r_ptr;
  logic [7:0] r_hold_cnt;

  logic [0:0] w_state_nxt;
  logic [7:0] w_grant_nxt;
  logic [2:0] w_idx_nxt;
  logic [2:0] w_ptr_nxt;
  logic [7:0] w_hold_cnt_nxt;

  logic       w_release;
  logic [2:0] w_search_ptr;
  logic       w_found;
  logic [2:0] w_win;

  // Release is evaluated first so the same edge can re-arbitrate from the advanced pointer.
  always_comb begin
    w_release = (r_state == c_S_GRANT) &&
                (!req[r_idx] || ((MAX_HOLD != 0) && (r_hold_cnt == c_HOLD_LAST)));
    w_search_ptr = w_release ? (r_idx + 3'd1) : r_ptr;
    w_found = 1'b0;
    w_win   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[w_search_ptr + 3'(i)]) begin
        w_found = 1'b1;
        w_win   = w_search_ptr + 3'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= c_S_IDLE;
      r_grant    <= 8'h00;
      r_idx      <= 3'd0;
      r_ptr      <= 3'd0;
      r_hold_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_idx      <= w_idx_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_idx_nxt      = r_idx;
    w_ptr_nxt      = r_ptr;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      c_S_IDLE: begin
        if (w_found) begin
          w_state_nxt    = c_S_GRANT;
          w_grant_nxt    = 8'd1 << w_win;
          w_idx_nxt      = w_win;
          w_hold_cnt_nxt = 8'd0;
        end
      end
      c_S_GRANT: begin
        if (w_release) begin
          w_ptr_nxt = r_idx + 3'd1;
          if (w_found) begin
            w_grant_nxt    = 8'd1 << w_win;
            w_idx_nxt      = w_win;
            w_hold_cnt_nxt = 8'd0;
          end else begin
            w_state_nxt = c_S_IDLE;
            w_grant_nxt = 8'h00;
          end
        end else if ((MAX_HOLD != 0) && (r_hold_cnt != c_HOLD_SAT)) begin
          w_hold_cnt_nxt = r_hold_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = c_S_IDLE;
        w_grant_nxt = 8'h00;
      end
    endcase
  end

  always_comb begin
    grant       = r_grant;
    grant_valid = (r_state == c_S_GRANT);
    grant_idx   = r_idx;
    any_req     = |req;
  end

endmodule
`default_nettype wire
